// File: rtl/multiword_add_seq.sv
// Multi-word add sequencer: steps one shared WORD_W-bit adder over NWORDS words, LSW first.
// Optional subtract mode (sub port, inverted B, carry-in forced to 1) is built when MWADD_SUB_EN is defined.
module multiword_add_seq #(
    parameter int WORD_W = 16,
    parameter int NWORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_W*NWORDS-1:0] op_a,
    input  logic [WORD_W*NWORDS-1:0] op_b,
    input  logic                     cin,
`ifdef MWADD_SUB_EN
    input  logic                     sub,
`endif
    output logic [WORD_W-1:0]        add_x,
    output logic [WORD_W-1:0]        add_y,
    output logic                     add_c0,
    input  logic [WORD_W-1:0]        add_s,
    input  logic                     add_c4,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_W*NWORDS-1:0] sum,
    output logic                     cout,
    output logic                     busy
);

    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                         state;
    state_t                         state_nxt;
    logic [NWORDS-1:0][WORD_W-1:0]  a_q;
    logic [NWORDS-1:0][WORD_W-1:0]  b_q;
    logic [NWORDS-1:0][WORD_W-1:0]  sum_q;
    logic [IDX_W-1:0]               idx;
    logic                           carry;
    logic                           cout_q;
    logic                           accept;
    logic                           last;
    logic [WORD_W*NWORDS-1:0]       b_in;
    logic                           carry_in;

`ifdef MWADD_SUB_EN
    // Subtraction is A + ~B + 1; the caller's cin has no meaning here.
    assign b_in     = sub ? ~op_b : op_b;
    assign carry_in = sub ? 1'b1 : cin;
`else
    assign b_in     = op_b;
    assign carry_in = cin;
`endif

    assign accept = in_valid && in_ready;
    assign last   = (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_x     = '0;
        add_y     = '0;
        add_c0    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                add_x  = a_q[idx];
                add_y  = b_q[idx];
                add_c0 = carry;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: captured operands carry no reset; they are always reloaded on accept before being read.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= op_a;
            b_q <= b_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx    <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            idx   <= '0;
            carry <= carry_in;
            sum_q <= '0;
        end else if (state == RUN) begin
            sum_q[idx] <= add_s;
            carry      <= add_c4;
            if (last) begin
                cout_q <= add_c4;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq: models the shared adder, scoreboards results.
module tb_multiword_add_seq;

    localparam int WORD_W = 16;
    localparam int NWORDS = 4;
    localparam int OPW    = WORD_W * NWORDS;

    typedef struct {
        logic [OPW-1:0] sum;
        logic           cout;
    } exp_t;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              cin       = 1'b0;
    logic              sub       = 1'b0;
    logic              out_ready = 1'b0;
    logic [OPW-1:0]    op_a      = '0;
    logic [OPW-1:0]    op_b      = '0;
    logic              in_ready;
    logic              out_valid;
    logic              cout;
    logic              busy;
    logic              add_c0;
    logic              add_c4;
    logic [OPW-1:0]    sum;
    logic [WORD_W-1:0] add_x;
    logic [WORD_W-1:0] add_y;
    logic [WORD_W-1:0] add_s;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Shared ripple adder the sequencer drives.
    assign {add_c4, add_s} = {1'b0, add_x} + {1'b0, add_y} + {{WORD_W{1'b0}}, add_c0};

    multiword_add_seq #(.WORD_W(WORD_W), .NWORDS(NWORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
`ifdef MWADD_SUB_EN
        .sub       (sub),
`endif
        .add_x     (add_x),
        .add_y     (add_y),
        .add_c0    (add_c0),
        .add_s     (add_s),
        .add_c4    (add_c4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [OPW:0] got, input logic [OPW:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge in IDLE; returns at a negedge back in IDLE.
    task automatic run_op(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input logic c,
                          input logic s, input int stall, input logic hold);
        exp_t              e;
        logic [OPW:0]      full;
        logic [WORD_W-1:0] wx;
        logic [WORD_W-1:0] wy;
        int                n;
        if (s) full = {1'b0, a} + {1'b0, ~b} + 65'd1;
        else   full = {1'b0, a} + {1'b0, b} + {{OPW{1'b0}}, c};
        e.sum  = full[OPW-1:0];
        e.cout = full[OPW];
        sb.push_back(e);

        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        cin      = c;
        sub      = s;
        check("idle_in_ready", in_ready, 1);
        tick();
        op_a = ~a;
        op_b = a ^ b;
        cin  = ~c;
        if (!hold) in_valid = 1'b0;

        n = 0;
        while (!out_valid && n <= NWORDS + 2) begin
            check("run_in_ready", in_ready, 0);
            check("run_busy", busy, 1);
            if (n < NWORDS) begin
                wx = a[n*WORD_W +: WORD_W];
                wy = b[n*WORD_W +: WORD_W];
                if (s) wy = ~wy;
                check("run_add_x", add_x, wx);
                check("run_add_y", add_y, wy);
            end
            tick();
            n++;
        end
        check("latency", n, NWORDS);

        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("sum", sum, e.sum);
            check("cout", cout, e.cout);
        end

        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_out_valid", out_valid, 1);
            check("stall_sum", sum, e.sum);
            check("stall_cout", cout, e.cout);
            check("stall_in_ready", in_ready, 0);
            check("stall_busy", busy, 1);
            check("stall_add_x", add_x, 0);
        end

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("ret_out_valid", out_valid, 0);
        check("ret_busy", busy, 0);
        check("ret_in_ready", in_ready, 1);
        if (!hold) in_valid = 1'b0;
    endtask

    initial begin
        logic [OPW-1:0] ra;
        logic [OPW-1:0] rb;
        logic [WORD_W-1:0] w2;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_add_x", add_x, 0);
        rst_n = 1'b1;
        #1;
        check("rst_release_in_ready", in_ready, 1);
        @(negedge clk);

        // Word-0 carry into word 1, then a 5-cycle consumer stall
        run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 5, 1'b0);
        // Carry ripples through every word
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 0, 1'b0);
        // in_valid held with junk operands through RUN; next accept only in IDLE
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 1, 1'b1);
        run_op(64'h8000_0000_8000_0000, 64'h8000_0000_8000_0000, 1'b1, 1'b0, 0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'b0, k, 1'b0);
        end

        // Reset while idx==2 in RUN discards the operation
        in_valid = 1'b1;
        op_a     = 64'hAAAA_BBBB_CCCC_DDDD;
        op_b     = 64'h1111_2222_3333_4444;
        cin      = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        w2 = 16'hBBBB;
        check("abort_add_x_idx2", add_x, w2);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready_forced", in_ready, 0);
        @(negedge clk);
        tick();
        check("abort_sum", sum, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_cout", cout, 0);
        rst_n = 1'b1;
        #1;
        check("abort_in_ready", in_ready, 1);
        @(negedge clk);
        run_op(64'h0000_0001_0000_FFFF, 64'h0000_0000_0000_0001, 1'b1, 1'b0, 0, 1'b0);

`ifdef MWADD_SUB_EN
        run_op(64'h10, 64'h20, 1'b0, 1'b1, 0, 1'b0);
        run_op(64'h20, 64'h10, 1'b1, 1'b1, 0, 1'b0);
        sub = 1'b0;
`endif

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
